// File: rtl/gvc_pkg.sv
// gvc_pkg: shared FSM states, OP encodings and vector count for gate_vector_checker.
package gvc_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;
  localparam int OP_AND = 0;
  localparam int OP_OR = 1;
  localparam int OP_XOR = 2;
  localparam int NUM_VEC = 4;
endpackage

// File: rtl/gvc_ref_gate.sv
// gvc_ref_gate: expected output of a two-input gate; unknown OP values fall back to AND.
module gvc_ref_gate import gvc_pkg::*; #(
  parameter int OP = OP_AND
) (
  input  logic a,
  input  logic b,
  output logic expected
);
  always_comb expected = (OP == OP_OR) ? (a | b) : (OP == OP_XOR) ? (a ^ b) : (a & b);
endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: sweeps the four 2-bit vectors into a gate DUT and counts mismatches.
// Define GVC_FAIL_CAPTURE_EN to add fail_valid/fail_vec capture of the first failing vector.
module gate_vector_checker import gvc_pkg::*; #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W = 8,
  parameter int OP = OP_AND
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic [1:0]       vec_idx,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
`ifdef GVC_FAIL_CAPTURE_EN
  ,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
`endif
);
  state_t state_q, state_d;
  logic [1:0] vec_idx_q, vec_idx_d;
  logic dut_a_q, dut_a_d, dut_b_q, dut_b_d, done_q, done_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [3:0] cnt_q, cnt_d;
  logic expected, accept, mismatch;
  gvc_ref_gate #(.OP(OP)) u_ref (.a(dut_a_q), .b(dut_b_q), .expected(expected));
  assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign mismatch = (state_q == ST_SAMPLE) && (dut_y != expected);
  always_comb begin
    state_d = state_q;
    vec_idx_d = vec_idx_q;
    dut_a_d = dut_a_q;
    dut_b_d = dut_b_q;
    err_count_d = err_count_q;
    done_d = done_q;
    cnt_d = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (accept) begin
        state_d = ST_DRIVE;
        vec_idx_d = 2'd0;
        dut_a_d = 1'b0;
        dut_b_d = 1'b0;
        err_count_d = '0;
        done_d = 1'b0;
      end
      ST_DRIVE: begin
        state_d = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_SAMPLE;
        cnt_d = 4'(SETTLE_CYCLES);
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? ST_SAMPLE : ST_SETTLE;
      end
      ST_SAMPLE: begin
        err_count_d = (mismatch && err_count_q != '1) ? err_count_q + 1'b1 : err_count_q;
        if (vec_idx_q == 2'(NUM_VEC - 1)) begin
          state_d = ST_DONE;
          done_d = 1'b1;
        end else begin
          state_d = ST_DRIVE;
          vec_idx_d = vec_idx_q + 2'd1;
          dut_a_d = vec_idx_d[1];
          dut_b_d = vec_idx_d[0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      vec_idx_q <= 2'd0;
      dut_a_q <= 1'b0;
      dut_b_q <= 1'b0;
      err_count_q <= '0;
      done_q <= 1'b0;
      cnt_q <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_idx_q <= vec_idx_d;
      dut_a_q <= dut_a_d;
      dut_b_q <= dut_b_d;
      err_count_q <= err_count_d;
      done_q <= done_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef GVC_FAIL_CAPTURE_EN
  logic fail_valid_q, fail_valid_d;
  logic [1:0] fail_vec_q, fail_vec_d;
  always_comb begin
    fail_valid_d = accept ? 1'b0 : (fail_valid_q | mismatch);
    fail_vec_d = accept ? 2'd0 : (mismatch && !fail_valid_q) ? vec_idx_q : fail_vec_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_valid_q <= 1'b0;
      fail_vec_q <= 2'd0;
    end else begin
      fail_valid_q <= fail_valid_d;
      fail_vec_q <= fail_vec_d;
    end
  end
  assign fail_valid = fail_valid_q;
  assign fail_vec = fail_vec_q;
`endif
  assign dut_a = dut_a_q;
  assign dut_b = dut_b_q;
  assign vec_idx = vec_idx_q;
  assign err_count = err_count_q;
  assign done = done_q;
  assign busy = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
  assign pass = done_q && (err_count_q == '0);
endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: four checker instances (settle 1/0/3, XOR with 1-bit counter) driving modelled gates.
module tb_gate_vector_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start[4], a[4], b[4], y[4], busy[4], done[4], pass[4], fvld[4];
  logic [1:0] vidx[4], fvec[4];
  logic [7:0] err0, err1, err2;
  logic [0:0] err3;
  int mode[4];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    int id;
    logic [7:0] err;
    logic pass;
    int done_at;
    logic fv;
    logic [1:0] fvec;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(8), .OP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .dut_a(a[0]), .dut_b(b[0]), .dut_y(y[0]),
    .vec_idx(vidx[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err0)
`ifdef GVC_FAIL_CAPTURE_EN
    , .fail_valid(fvld[0]), .fail_vec(fvec[0])
`endif
  );
  gate_vector_checker #(.SETTLE_CYCLES(0), .ERR_W(8), .OP(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .dut_a(a[1]), .dut_b(b[1]), .dut_y(y[1]),
    .vec_idx(vidx[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err1)
`ifdef GVC_FAIL_CAPTURE_EN
    , .fail_valid(fvld[1]), .fail_vec(fvec[1])
`endif
  );
  gate_vector_checker #(.SETTLE_CYCLES(3), .ERR_W(8), .OP(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .dut_a(a[2]), .dut_b(b[2]), .dut_y(y[2]),
    .vec_idx(vidx[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err2)
`ifdef GVC_FAIL_CAPTURE_EN
    , .fail_valid(fvld[2]), .fail_vec(fvec[2])
`endif
  );
  gate_vector_checker #(.SETTLE_CYCLES(1), .ERR_W(1), .OP(2)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .dut_a(a[3]), .dut_b(b[3]), .dut_y(y[3]),
    .vec_idx(vidx[3]), .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(err3)
`ifdef GVC_FAIL_CAPTURE_EN
    , .fail_valid(fvld[3]), .fail_vec(fvec[3])
`endif
  );

  // Gate models: mode 0 correct, 1 stuck-at-1, 2 inverted, 3 stuck-at-0.
  function automatic logic gate_f(input int op, input logic fa, input logic fb);
    return (op == 1) ? (fa | fb) : (op == 2) ? (fa ^ fb) : (fa & fb);
  endfunction
  always_comb begin
    for (int k = 0; k < 4; k++)
      y[k] = (mode[k] == 1) ? 1'b1 : (mode[k] == 3) ? 1'b0 :
             (gate_f((k == 3) ? 2 : 0, a[k], b[k]) ^ (mode[k] == 2));
  end

  function automatic logic [7:0] get_err(input int i);
    return (i == 0) ? err0 : (i == 1) ? err1 : (i == 2) ? err2 : {7'd0, err3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  logic busy_p[4], done_p[4];
  logic [1:0] ab_p[4];
  logic [7:0] seq[4];
  initial for (int k = 0; k < 4; k++) begin busy_p[k] = 0; done_p[k] = 0; ab_p[k] = 0; seq[k] = 0; end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (busy[i] && !busy_p[i]) seq[i] = 8'd0;
      if (busy[i] && (!busy_p[i] || {a[i], b[i]} != ab_p[i])) seq[i] = {seq[i][5:0], a[i], b[i]};
      if (done[i] && !done_p[i]) begin
        if (q.size() == 0) chk("sb_unexpected_done", 32'd1, 32'd0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_id", i, e.id);
          chk("err_count", get_err(i), e.err);
          chk("pass", pass[i], e.pass);
          chk("done_cycle", cyc, e.done_at);
          chk("vector_order", seq[i], 8'h1B);
          chk("final_vec", {vidx[i], a[i], b[i]}, 4'hF);
          chk("busy_in_done", busy[i], 0);
`ifdef GVC_FAIL_CAPTURE_EN
          chk("fail_valid", fvld[i], e.fv);
          chk("fail_vec", fvec[i], e.fvec);
`endif
        end
      end
      busy_p[i] = busy[i];
      done_p[i] = done[i];
      ab_p[i] = {a[i], b[i]};
    end
  end

  task automatic expect_sweep(input int i, input int s, input logic [7:0] e, input logic p,
                              input logic fv, input logic [1:0] fvc);
    exp_t x;
    x = '{id: i, err: e, pass: p, done_at: cyc + 1 + 4 * (2 + s), fv: fv, fvec: fvc};
    q.push_back(x);
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (!done[i] && n < 100) begin @(negedge clk); n++; end
    if (!done[i]) chk("done_timeout", 0, 1);
  endtask

  task automatic pulse(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic sweep(input int i, input int s, input logic [7:0] e, input logic p,
                       input logic fv, input logic [1:0] fvc);
    expect_sweep(i, s, e, p, fv, fvc);
    pulse(i);
    wait_done(i);
    @(negedge clk);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 4; k++) begin start[k] = 0; mode[k] = 0; end
    repeat (3) @(negedge clk);
    chk("reset_outputs", {a[0], b[0], vidx[0], busy[0], done[0], pass[0], err0}, 0);
    rst_n = 1'b1;
    sweep(0, 1, 8'd0, 1'b1, 1'b0, 2'd0);
    mode[0] = 1;
    sweep(0, 1, 8'd3, 1'b0, 1'b1, 2'd0);
    mode[0] = 0;
    sweep(0, 1, 8'd0, 1'b1, 1'b0, 2'd0);
    pulse(0);
    n = 0;
    while (vidx[0] != 2'd2 && n < 50) begin @(negedge clk); n++; end
    chk("reach_vec2", vidx[0], 2);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", {a[0], b[0], vidx[0], busy[0], done[0], pass[0], err0}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", {busy[0], done[0], vidx[0]}, 0);
    sweep(0, 1, 8'd0, 1'b1, 1'b0, 2'd0);
    expect_sweep(0, 1, 8'd0, 1'b1, 1'b0, 2'd0);
    pulse(0);
    repeat (3) @(negedge clk);
    pulse(0);
    wait_done(0);
    @(negedge clk);
    mode[0] = 3;
    expect_sweep(0, 1, 8'd1, 1'b0, 1'b1, 2'd3);
    pulse(0);
    chk("restart_clears", {done[0], pass[0], err0, vidx[0], busy[0]}, 1);
    wait_done(0);
    @(negedge clk);
    mode[0] = 0;
    sweep(1, 0, 8'd0, 1'b1, 1'b0, 2'd0);
    sweep(2, 3, 8'd0, 1'b1, 1'b0, 2'd0);
    mode[2] = 3;
    sweep(2, 3, 8'd1, 1'b0, 1'b1, 2'd3);
    mode[3] = 2;
    sweep(3, 1, 8'd1, 1'b0, 1'b1, 2'd0);
    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("sb_leftover", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gate_vector_checker.md
GATE_VECTOR_CHECKER -- requirements
Module: gate_vector_checker

Interface
REQ-001 The block SHALL use one clock, `clk`, and an asynchronous, active-low reset, `rst_n`.
REQ-002 Parameter SETTLE_CYCLES, default 1: number of wait cycles between driving a vector and sampling `dut_y`; legal range 0..15.
REQ-003 Parameter ERR_W, default 8: width of the mismatch counter.
REQ-004 Parameter OP, default 0: expected function of the device under test; 0 = AND, 1 = OR, 2 = XOR.
REQ-005 Ports SHALL be as follows:
- `clk`, input, 1 bit: rising-edge clock.
- `rst_n`, input, 1 bit: asynchronous reset, active low.
- `start`, input, 1 bit: one-cycle pulse that begins a sweep.
- `dut_a`, output, 1 bit: registered stimulus bit A to the DUT.
- `dut_b`, output, 1 bit: registered stimulus bit B to the DUT.
- `dut_y`, input, 1 bit: response from the DUT.
- `vec_idx`, output, 2 bits: index of the current vector.
- `busy`, output, 1 bit: high while a sweep is in progress.
- `done`, output, 1 bit: sweep complete; held until the next sweep starts.
- `pass`, output, 1 bit: valid only when `done`=1; high when no mismatch occurred.
- `err_count`, output, ERR_W bits: number of mismatches in the current sweep.

Function
REQ-006 The state machine SHALL have the states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-007 In IDLE or DONE, `start`=1 SHALL move the block to DRIVE on the next edge and SHALL clear `vec_idx`, `err_count`, `done` and `pass` on that same edge.
REQ-008 `start` SHALL be ignored while `busy`=1.
REQ-009 On entry to DRIVE, the block SHALL set `dut_a`=`vec_idx`[1] and `dut_b`=`vec_idx`[0]. The vector order is therefore 00, 01, 10, 11.
REQ-010 DRIVE SHALL last one cycle.
- If SETTLE_CYCLES>0, DRIVE SHALL go to SETTLE, which lasts exactly SETTLE_CYCLES cycles.
- If SETTLE_CYCLES=0, DRIVE SHALL go directly to SAMPLE.
REQ-011 In SAMPLE (one cycle), the block SHALL compare `dut_y` with OP applied to (`dut_a`, `dut_b`). On a mismatch it SHALL increment `err_count`.
REQ-012 `err_count` SHALL saturate at 2^ERR_W-1 and SHALL NOT wrap.
REQ-013 After SAMPLE:
- if `vec_idx`<3, the block SHALL increment `vec_idx` and return to DRIVE;
- if `vec_idx`=3, it SHALL go to DONE and SHALL leave `vec_idx` at 3.
REQ-014 In DONE, `done`=1, `busy`=0 and `pass` = (`err_count`==0). `dut_a` and `dut_b` SHALL hold the last vector applied.
REQ-015 `busy` SHALL be 1 in the states DRIVE, SETTLE and SAMPLE, and 0 otherwise.
REQ-016 Timing SHALL be exact:
- each vector SHALL take 2+SETTLE_CYCLES cycles;
- `done` SHALL rise 4×(2+SETTLE_CYCLES) cycles after the edge that accepted `start`.
REQ-017 Unsupported OP values SHALL be treated as AND.

Reset
REQ-018 While `rst_n`=0, all outputs SHALL be 0 and the state SHALL be IDLE, immediately and without waiting for a clock edge.
REQ-019 If `rst_n` is asserted during a sweep, the sweep SHALL be abandoned. After release, the block SHALL remain in IDLE until a new `start` pulse.
REQ-020 The first clock edge after `rst_n` rises SHALL be a normal functional edge; if `start`=1 on that edge, it SHALL be accepted.

Configuration
REQ-021 Macro GVC_FAIL_CAPTURE_EN, when defined, SHALL add two outputs:
- `fail_valid`, output, 1 bit;
- `fail_vec`, output, 2 bits.
On the first mismatch of a sweep, the block SHALL latch the `vec_idx` of that vector into `fail_vec` and set `fail_valid`=1. Both SHALL be held until the next accepted `start` or reset, which clears them to 0.
REQ-022 Without GVC_FAIL_CAPTURE_EN, these ports and their registers SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-023 The shared package gvc_pkg SHALL hold the following; no other items belong in it:
- the state enum typedef;
- the OP encoding constants (OP_AND=0, OP_OR=1, OP_XOR=2);
- the vector-count constant NUM_VEC=4.
REQ-024 The expected-value function SHALL be a sub-module, gvc_ref_gate: combinational, inputs a, b and OP, output expected. All sequencing SHALL remain in the top module.

Verification
REQ-025 The bench SHALL cover the following directed scenarios, with SETTLE_CYCLES=1 unless stated:
1. Correct AND DUT, OP=0, `start` pulse → `dut_a`/`dut_b` = 00, 01, 10, 11; `done` rises 12 cycles after the start edge; `pass`=1; `err_count`=0.
2. OP=0, DUT output stuck at 1 → `err_count`=3, `pass`=0; with GVC_FAIL_CAPTURE_EN defined, `fail_vec`=0 and `fail_valid`=1.
3. SETTLE_CYCLES=0, correct AND DUT → `done` 8 cycles after start; SETTLE_CYCLES=3 → `done` 20 cycles after start.
4. `rst_n` pulsed low during vector 2 → all outputs 0 immediately; block stays in IDLE; a new `start` runs a full sweep giving `err_count`=0.
5. `start` re-pulsed while `busy`=1 → ignored, sweep timing unchanged; `start` in DONE → counters clear and a new sweep begins.
6. ERR_W=1, OP=2 (XOR), DUT output inverted → 4 mismatches saturate `err_count` at 1; `pass`=0.
